ps2_kbd_tx: RTL
===============

// Module: ps2_kbd_tx
// PURPOSE
//  PS/2 device-side transmitter. It serialises keyboard scancode bytes onto a PS/2 clock/data pair, which the
//  Microcomputer cores' PS/2 receivers consume. It is the sending end of the link that hps_io currently emulates.
//  A byte FIFO decouples scancode producers (HPS key events, test injectors) from the roughly 10 kHz line rate.
// PARAMETERS
//  CLK_HALF    2500  clk cycles per PS/2 clock half-period (50 MHz -> 10 kHz); must be >= 2
//  GAP_CYCLES  5000  idle cycles, with both lines high, between consecutive frames
//  FIFO_AW     4     log2 of FIFO depth (default depth 16)
// PORTS
//  clk        in   1        system clock (CLK_50M at top level)
//  reset      in   1        synchronous, active-high
//  din        in   8        scancode byte
//  din_valid  in   1        byte offered
//  din_ready  out  1        FIFO can accept; a byte transfers when din_valid & din_ready
//  ps2_clk    out  1        PS/2 clock to receiver, idle 1
//  ps2_data   out  1        PS/2 data to receiver, idle 1
//  ps2_clk_in in   1        host view of clock line (inhibit sense); ignored unless PS2_TX_INHIBIT_EN
//  busy       out  1        1 while a frame, gap or inhibit wait is in progress
//  level      out  FIFO_AW+1  FIFO occupancy
// BEHAVIOUR
//  Reset (synchronous, one cycle): ps2_clk=1, ps2_data=1, busy=0, level=0, din_ready=1, FIFO cleared, FSM->IDLE.
//  FIFO: din_ready = (level != depth), computed from the registered level, so no write is taken when full, even
//   if a pop happens in the same cycle. Simultaneous push and pop keeps level unchanged.
//   The head byte is popped only after its stop bit completes, so an aborted frame retains its byte.
//  Frame: 11 bits = start(0), d[0]..d[7] (LSB first), odd parity (~^d), stop(1).
//  FSM states: IDLE, LOAD, HIGH, LOW, GAP (+INHIBIT when the macro is defined).
//   IDLE: if level != 0 -> LOAD.
//   LOAD: latch the head into an 11-bit shift register, bit counter = 0 -> HIGH.
//   HIGH: ps2_clk=1; ps2_data = current bit, updated on the first cycle of HIGH. Stay CLK_HALF cycles -> LOW.
//   LOW: ps2_clk=0; data held. The receiver samples on this falling edge. Stay CLK_HALF cycles.
//    Then, if bit counter = 10: pop FIFO and go to GAP; otherwise increment the counter and go to HIGH.
//   GAP: both lines 1 for GAP_CYCLES cycles -> IDLE.
//  Latency: a byte accepted at cycle N into an empty FIFO while IDLE drives the start bit (ps2_data=0) at N+2.
//   The first ps2_clk falling edge is at N+2+CLK_HALF. A frame occupies 22*CLK_HALF cycles.
//  busy = 1 in LOAD/HIGH/LOW/GAP/INHIBIT.
//  Data never changes while ps2_clk=0. Exactly 11 falling edges per completed frame.
//  Half-period and gap counters are wide enough for their parameters; no wrap within a phase.
//  Reset mid-frame: lines return to 1 on the next cycle, the partial frame is discarded, and the FIFO (including the
//   head byte) is cleared.
// CONFIGURATION
//  PS2_TX_INHIBIT_EN defined:
//   - ps2_clk_in passes through a 2-flop synchroniser.
//   - Synchronised ps2_clk_in=0 in IDLE/GAP: no frame starts.
//   - Synchronised ps2_clk_in=0 in HIGH, for bit counter <= 9: abort. Lines go to 1 next cycle, state -> INHIBIT,
//     head byte kept.
//   - INHIBIT: wait for ps2_clk_in=1 continuously for GAP_CYCLES, then go to IDLE and resend the whole frame.
//   - Sensing is only done in HIGH; the block's own low clock is never treated as inhibit.
//  PS2_TX_INHIBIT_EN undefined: ps2_clk_in is unused, there is no INHIBIT state, and frames always complete.
// TESTING (CLK_HALF=4, GAP_CYCLES=8, FIFO_AW=2, unless noted)
//  1. Reset, then push 0x1C -> the bench decodes on ps2_clk falls: 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
//     First fall at push+6; ps2_clk and ps2_data stay 1 throughout the 8-cycle gap; busy=0 after the gap.
//  2. Back-to-back push 0xF0, 0x1C -> two frames, parity bits 1 then 0.
//     Second start bit exactly 8 cycles after the first frame's stop bit ends; level goes 2,1,0.
//  3. Hold din_valid with 6 distinct bytes while the line is slow -> din_ready=0 when level=4, no byte lost or
//     duplicated, output order equals input order.
//  4. Assert reset at bit 5 of 0xFF with level=3 -> next cycle ps2_clk=1, ps2_data=1, level=0;
//     no further falls seen; a new push of 0x00 sends a clean frame with parity 1.
//  5. (PS2_TX_INHIBIT_EN) Drive ps2_clk_in=0 during HIGH of bit 4 of 0x5A -> lines go to 1 and the partial frame is
//     abandoned. Release ps2_clk_in; after 8 cycles the full 0x5A frame is resent and level drops only then.
//  6. Check ps2_data is stable whenever ps2_clk=0, and there are 22*CLK_HALF cycles per frame, with CLK_HALF=2500
//     and one byte.

Source files
------------

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: a byte FIFO feeding an 11-bit frame serialiser (start, 8 data LSB first, odd parity, stop).
// Define PS2_TX_INHIBIT_EN to honour host inhibit sensed on ps2_clk_in. GAP_CYCLES must be >= 2, CLK_HALF >= 2.
module ps2_kbd_tx #(
  parameter int CLK_HALF   = 2500,
  parameter int GAP_CYCLES = 5000,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ps2_clk,
  output logic             ps2_data,
  input  logic             ps2_clk_in,
  output logic             busy,
  output logic [FIFO_AW:0] level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HW    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [HW-1:0]    HALF_LAST  = HW'(CLK_HALF - 1);
  // GAP is one cycle short because the following LOAD cycle also keeps both lines high
  localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    GAP
`ifdef PS2_TX_INHIBIT_EN
    , INHIBIT
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [HW-1:0]        half_cnt_q, half_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [10:0]          shreg_q, shreg_d;
  logic                 ps2_clk_q, ps2_clk_d;
  logic [7:0]           fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic                 push, pop;
  logic [7:0]           head;
  logic                 line_free;

  assign din_ready = (level_q != FULL_LEVEL);
  assign push      = din_valid & din_ready;
  assign head      = fifo_mem[rd_ptr_q];

`ifdef PS2_TX_INHIBIT_EN
  localparam logic [GW-1:0] INH_LAST = GW'(GAP_CYCLES - 1);
  logic [1:0] sync_q, sync_d;

  assign sync_d    = {sync_q[0], ps2_clk_in};
  assign line_free = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign line_free     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= din;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // ps2_data is shreg_q[0]; the register holds all ones whenever the line should idle high
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ps2_clk_d  = ps2_clk_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        ps2_clk_d = 1'b1;
        shreg_d   = '1;
        if (level_q != '0 && line_free) state_d = LOAD;
      end
      LOAD: begin
        shreg_d    = {1'b1, ~^head, head, 1'b0};
        bit_cnt_d  = '0;
        half_cnt_d = '0;
        ps2_clk_d  = 1'b1;
        state_d    = HIGH;
      end
      HIGH: begin
`ifdef PS2_TX_INHIBIT_EN
        if (!line_free && bit_cnt_q <= 4'd9) begin
          ps2_clk_d  = 1'b1;
          shreg_d    = '1;
          half_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = INHIBIT;
        end else
`endif
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          ps2_clk_d  = 1'b0;
          state_d    = LOW;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          ps2_clk_d  = 1'b1;
          if (bit_cnt_q == 4'd10) begin
            pop       = 1'b1;
            shreg_d   = '1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = {1'b1, shreg_q[10:1]};
            state_d   = HIGH;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = (level_q != '0 && line_free) ? LOAD : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`ifdef PS2_TX_INHIBIT_EN
      // The host must release the clock continuously for a full gap before the frame is resent
      INHIBIT: begin
        if (!line_free) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == INH_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        ps2_clk_d = 1'b1;
        shreg_d   = '1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      gap_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
      ps2_clk_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ps2_clk_q  <= ps2_clk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = shreg_q[0];
  assign busy     = (state_q != IDLE);
  assign level    = level_q;

endmodule
